// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl
// Runs one forward FFT pass through fft_ip for the stride-detection path.
// The input side frames an unsigned pixel stream into FFT_LEN-point blocks
// (sink_sop/sink_eop). The output side scans the returned spectrum and
// reports the first bin at or above MIN_BIN whose |re|+|im| exceeds THRESH.
//
// Ports
//   clk, rst_n        clock (posedge) and asynchronous active-low reset
//   start             1-cycle pulse, begins a frame when idle
//   pix_valid/ready   pixel stream handshake, pix_data is the pixel value
//   sink_*            fft_ip sink interface (data passed through, no latency)
//   inverse           tied 0, forward transform
//   source_*          fft_ip source interface (spectrum in)
//   busy              high whenever not idle
//   done              1-cycle pulse when found/stride are valid
//   found, stride     detection result, held until the next accepted start
module fft_frame_ctrl #(
   parameter  int FFT_LEN = 1024,
   parameter  int DATA_W  = 8,
   parameter  int FFT_W   = 12,
   parameter  int MIN_BIN = 300,
   parameter  int THRESH  = 38,
   localparam int IDX_W   = $clog2(FFT_LEN)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     pix_valid,
   input  logic [DATA_W-1:0]        pix_data,
   output logic                     pix_ready,
   output logic                     sink_valid,
   input  logic                     sink_ready,
   output logic                     sink_sop,
   output logic                     sink_eop,
   output logic [FFT_W-1:0]         sink_real,
   output logic [FFT_W-1:0]         sink_imag,
   output logic [1:0]               sink_error,
   output logic                     inverse,
   input  logic                     source_valid,
   output logic                     source_ready,
   input  logic                     source_sop,
   input  logic                     source_eop,
   input  logic signed [FFT_W-1:0]  source_real,
   input  logic signed [FFT_W-1:0]  source_imag,
   output logic                     busy,
   output logic                     done,
   output logic                     found,
   output logic [IDX_W-1:0]         stride
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FFT_LEN - 1);
   localparam logic [IDX_W-1:0] MIN_IDX  = IDX_W'(MIN_BIN);
   localparam logic [FFT_W:0]   THR_MAG  = (FFT_W + 1)'(THRESH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FEED,
      S_WAIT_OUT,
      S_SCAN,
      S_DONE
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [IDX_W-1:0]  in_cnt;
   logic [IDX_W-1:0]  out_cnt;
   logic [IDX_W-1:0]  bin_idx;
   logic [FFT_W:0]    mag;
   logic              sink_beat;
   logic              src_take;
   logic              hit;

   // Absolute value widened by one bit so the most negative input maps to
   // +2^(FFT_W-1) exactly instead of wrapping.
   function automatic logic [FFT_W:0] abs_ext(input logic signed [FFT_W-1:0] v);
      logic signed [FFT_W:0] w;
      w = {v[FFT_W-1], v};
      abs_ext = w[FFT_W] ? $unsigned(-w) : $unsigned(w);
   endfunction

   assign sink_real  = FFT_W'(pix_data);
   assign sink_imag  = '0;
   assign sink_error = 2'b00;
   assign inverse    = 1'b0;
   assign busy       = (state != S_IDLE);
   assign done       = (state == S_DONE);

   assign sink_beat = (state == S_FEED) && pix_valid && sink_ready;

   // Only the sop beat is taken while waiting; everything ahead of it is dropped.
   assign src_take = source_valid &&
                     ((state == S_SCAN) || ((state == S_WAIT_OUT) && source_sop));
   assign bin_idx  = (state == S_WAIT_OUT) ? '0 : out_cnt;
   assign mag      = abs_ext(source_real) + abs_ext(source_imag);
   assign hit      = (bin_idx >= MIN_IDX) && (mag > THR_MAG);

   always_comb begin
      state_nxt    = state;
      sink_valid   = 1'b0;
      pix_ready    = 1'b0;
      sink_sop     = 1'b0;
      sink_eop     = 1'b0;
      source_ready = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) state_nxt = S_FEED;
         end
         S_FEED: begin
            sink_valid = pix_valid;
            pix_ready  = sink_ready;
            sink_sop   = (in_cnt == '0);
            sink_eop   = (in_cnt == LAST_IDX);
            if (sink_beat && (in_cnt == LAST_IDX)) state_nxt = S_WAIT_OUT;
         end
         S_WAIT_OUT: begin
            source_ready = 1'b1;
            if (source_valid && source_sop) state_nxt = S_SCAN;
         end
         S_SCAN: begin
            source_ready = 1'b1;
            if (source_valid && (source_eop || (out_cnt == LAST_IDX))) state_nxt = S_DONE;
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         in_cnt  <= '0;
         out_cnt <= '0;
         found   <= 1'b0;
         stride  <= '0;
      end else begin
         state <= state_nxt;
         if ((state == S_IDLE) && start) begin
            in_cnt  <= '0;
            out_cnt <= '0;
            found   <= 1'b0;
            stride  <= '0;
         end else if (sink_beat) begin
            in_cnt <= in_cnt + IDX_W'(1);
         end
         // The final beat is evaluated here in the same cycle the FSM heads
         // to DONE, so a last-bin crossing is still reported.
         if (src_take) begin
            out_cnt <= bin_idx + IDX_W'(1);
            if (hit && !found) begin
               found  <= 1'b1;
               stride <= bin_idx;
            end
         end
      end
   end

endmodule
